// File: rtl/axis_conv_pkg.sv
// axis_conv_pkg: state encoding and window helpers shared by the KxK window generator.
package axis_conv_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   function automatic int idx(input int i, input int j, input int k);
      return i * k + j;
   endfunction

   function automatic int win_count(input int n, input int m, input int k);
      return (m - k + 1) * (n - k + 1);
   endfunction

endpackage

// File: rtl/axis_conv_window_kxk_if.sv
// axis_conv_window_kxk_if: pixel input stream and flattened window output stream.
interface axis_conv_window_kxk_if #(
   parameter int DATA_W = 32,
   parameter int K      = 3
);
   logic [DATA_W-1:0]     s_axis_tdata;
   logic                  s_axis_tvalid;
   logic                  s_axis_tready;
   logic [K*K*DATA_W-1:0] m_axis_tdata;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic                  m_axis_tlast;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
endinterface

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one image row of storage, synchronous write, asynchronous read.
module conv_line_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 640,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;

   assign rdata = mem[addr];
endmodule

// File: rtl/axis_conv_window_kxk.sv
// axis_conv_window_kxk: KxK sliding-window generator over a raster pixel stream.
module axis_conv_window_kxk
   import axis_conv_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int K        = 3,
   parameter int MAX_COLS = 640,
   parameter int COL_W    = 10,
   parameter int ROW_W    = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [COL_W-1:0]     cfg_cols,
   input  logic [ROW_W-1:0]     cfg_rows,
   axis_conv_window_kxk_if.slave axis,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err
);
   state_t            state;
   logic [COL_W-1:0]  col_cnt, n_cols;
   logic [ROW_W-1:0]  row_cnt, n_rows;
   logic [DATA_W-1:0] win  [K][K];
   logic [DATA_W-1:0] colv [K];
   logic              accept, emit, last_px, row_end, legal;

   assign busy    = state != IDLE;
   assign axis.s_axis_tready = state == RUN && (!axis.m_axis_tvalid || axis.m_axis_tready);
   assign accept  = axis.s_axis_tvalid && axis.s_axis_tready;
   assign row_end = col_cnt == n_cols - COL_W'(1);
   assign last_px = row_end && row_cnt == n_rows - ROW_W'(1);
   assign emit    = accept && row_cnt >= ROW_W'(K - 1) && col_cnt >= COL_W'(K - 1);
   assign legal   = cfg_cols >= COL_W'(K) && cfg_cols <= COL_W'(MAX_COLS) && cfg_rows >= ROW_W'(K);

   // colv[k] is the pixel of row r-(K-1)+k at the current column; the newest comes straight from the input
   assign colv[K-1] = axis.s_axis_tdata;

   for (genvar k = 0; k < K - 1; k++) begin : g_lb
      conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(MAX_COLS), .ADDR_W(COL_W)) u_lb (
         .clk   (clk),
         .we    (accept),
         .addr  (col_cnt),
         .wdata (colv[k+1]),
         .rdata (colv[k])
      );
   end

   for (genvar i = 0; i < K; i++) begin : g_row
      for (genvar j = 0; j < K; j++) begin : g_col
         assign axis.m_axis_tdata[idx(i, j, K)*DATA_W +: DATA_W] = win[i][j];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         col_cnt <= '0;
         row_cnt <= '0;
         n_cols  <= '0;
         n_rows  <= '0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
         axis.m_axis_tvalid <= 1'b0;
         axis.m_axis_tlast  <= 1'b0;
         for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
               win[i][j] <= '0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         if (emit) begin
            axis.m_axis_tvalid <= 1'b1;
            axis.m_axis_tlast  <= last_px;
         end else if (axis.m_axis_tready) begin
            axis.m_axis_tvalid <= 1'b0;
            axis.m_axis_tlast  <= 1'b0;
         end
         if (accept) begin
            for (int i = 0; i < K; i++) begin
               for (int j = 0; j < K - 1; j++)
                  win[i][j] <= win[i][j+1];
               win[i][K-1] <= colv[i];
            end
            col_cnt <= row_end ? '0 : col_cnt + COL_W'(1);
            row_cnt <= row_end ? row_cnt + ROW_W'(1) : row_cnt;
         end
         case (state)
            IDLE:
               if (start) begin
                  if (legal) begin
                     state   <= RUN;
                     n_cols  <= cfg_cols;
                     n_rows  <= cfg_rows;
                     col_cnt <= '0;
                     row_cnt <= '0;
                  end else
                     cfg_err <= 1'b1;
               end
            RUN:
               if (accept && last_px) state <= FLUSH;
            FLUSH:
               if (axis.m_axis_tvalid && axis.m_axis_tready) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axis_conv_window_kxk.sv
// tb_axis_conv_window_kxk: randomized scoreboard bench for K=3 and K=5 window generators.
module tb_axis_conv_window_kxk;
   import axis_conv_pkg::*;

   localparam int DW = 32, MC = 640, CW = 10, RW = 10, WMAX = 25 * DW;

   typedef struct {
      logic [WMAX-1:0] d;
      bit              l;
   } exp_t;

   logic          clk = 1'b0, reset = 1'b1;
   logic          start [2];
   logic [CW-1:0] cols  [2];
   logic [RW-1:0] rows  [2];
   logic          busy  [2], done [2], cerr [2];

   axis_conv_window_kxk_if #(.DATA_W(DW), .K(3)) b3 ();
   axis_conv_window_kxk_if #(.DATA_W(DW), .K(5)) b5 ();

   axis_conv_window_kxk #(.DATA_W(DW), .K(3), .MAX_COLS(MC), .COL_W(CW), .ROW_W(RW)) dut3 (
      .clk(clk), .reset(reset), .start(start[0]), .cfg_cols(cols[0]), .cfg_rows(rows[0]),
      .axis(b3.slave), .busy(busy[0]), .done(done[0]), .cfg_err(cerr[0]));

   axis_conv_window_kxk #(.DATA_W(DW), .K(5), .MAX_COLS(MC), .COL_W(CW), .ROW_W(RW)) dut5 (
      .clk(clk), .reset(reset), .start(start[1]), .cfg_cols(cols[1]), .cfg_rows(rows[1]),
      .axis(b5.slave), .busy(busy[1]), .done(done[1]), .cfg_err(cerr[1]));

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0;
   exp_t eq [2][$];
   logic [DW-1:0] cur_img [$];
   logic [WMAX-1:0] prev_d [2];
   bit   prev_stall [2], first_pend [2];
   int   wcnt [2], ndone [2], acc_cyc [2];
   bit   rnd_rdy = 1'b0, chk638 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk_w(string nm, logic [WMAX-1:0] act, logic [WMAX-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic void chk_i(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   task automatic die(string nm);
      bad++;
      total++;
      $display("FAIL %s: timeout", nm);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "aborted");
   endtask

   function automatic logic [WMAX-1:0] mdata(int s);
      return s != 0 ? b5.m_axis_tdata : WMAX'(b3.m_axis_tdata);
   endfunction
   function automatic bit mvalid(int s); return s != 0 ? b5.m_axis_tvalid : b3.m_axis_tvalid; endfunction
   function automatic bit mready(int s); return s != 0 ? b5.m_axis_tready : b3.m_axis_tready; endfunction
   function automatic bit mlast(int s);  return s != 0 ? b5.m_axis_tlast  : b3.m_axis_tlast;  endfunction
   function automatic bit sready(int s); return s != 0 ? b5.s_axis_tready : b3.s_axis_tready; endfunction

   task automatic set_px(int s, bit v, logic [DW-1:0] d);
      if (s != 0) begin
         b5.s_axis_tvalid = v;
         b5.s_axis_tdata  = d;
      end else begin
         b3.s_axis_tvalid = v;
         b3.s_axis_tdata  = d;
      end
   endtask

   // downstream ready: always 1, or a coin flip every cycle
   initial begin
      b3.m_axis_tready = 1'b1;
      b5.m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         b3.m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         b5.m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic mon(int s);
      logic [WMAX-1:0] d;
      logic [DW-1:0] ctr;
      exp_t e;
      d = mdata(s);
      if (prev_stall[s]) begin
         chk_i("stall_hold_valid", int'(mvalid(s)), 1);
         chk_w("stall_hold_data", d, prev_d[s]);
      end
      if (mvalid(s) && first_pend[s]) begin
         first_pend[s] = 1'b0;
         chk_i("first_window_latency", cyc, acc_cyc[s]);
      end
      if (mvalid(s) && !mready(s)) chk_i("s_tready_when_stalled", int'(sready(s)), 0);
      if (mvalid(s) && mready(s)) begin
         if (eq[s].size() == 0) begin
            bad++;
            total++;
            $display("FAIL unexpected_window: got %0h expected none", d);
         end else begin
            e = eq[s].pop_front();
            chk_w("window_data", d, e.d);
            chk_i("window_tlast", int'(mlast(s)), int'(e.l));
         end
         if (chk638 && s == 0 && wcnt[0] == 638) begin
            ctr = d[idx(1, 1, 3)*DW +: DW];
            chk_w("center_of_window_638", WMAX'(ctr), WMAX'(cur_img[2*640+1]));
         end
         wcnt[s]++;
      end
      if (done[s]) ndone[s]++;
      prev_stall[s] = mvalid(s) && !mready(s);
      prev_d[s] = d;
   endtask

   initial forever begin
      @(negedge clk);
      if (!reset) begin
         mon(0);
         mon(1);
      end
   end

   // reference: every valid output position of the frame, in raster order, built from the image directly
   task automatic run_frame(int s, int n, int m, bit seq, int restart_at, int abort_after);
      int k, t, wc0, nd0;
      exp_t e;
      k = s != 0 ? 5 : 3;
      cur_img = {};
      for (int p = 0; p < n * m; p++) cur_img.push_back(seq ? DW'(p) : DW'($urandom));
      for (int r = k - 1; r < m; r++)
         for (int c = k - 1; c < n; c++) begin
            e.d = '0;
            for (int i = 0; i < k; i++)
               for (int j = 0; j < k; j++)
                  e.d[idx(i, j, k)*DW +: DW] = cur_img[(r - k + 1 + i) * n + (c - k + 1 + j)];
            e.l = (r == m - 1) && (c == n - 1);
            eq[s].push_back(e);
         end
      wc0 = wcnt[s];
      nd0 = ndone[s];
      start[s] = 1'b1;
      cols[s]  = CW'(n);
      rows[s]  = RW'(m);
      @(posedge clk);
      #1;
      start[s] = 1'b0;
      first_pend[s] = 1'b1;
      for (int p = 0; p < n * m; p++) begin
         set_px(s, 1'b1, cur_img[p]);
         if (p == restart_at) begin
            start[s] = 1'b1;
            cols[s]  = CW'(4);
         end
         t = 0;
         forever begin
            @(negedge clk);
            if (sready(s)) break;
            if (++t > 2000) die("pixel_accept");
         end
         if (p == (k - 1) * n + k - 1) acc_cyc[s] = cyc + 1;
         @(posedge clk);
         #1;
         start[s] = 1'b0;
         if (p == abort_after) begin
            set_px(s, 1'b0, '0);
            #2 reset = 1'b1;
            #1;
            chk_i("abort_busy", int'(busy[s]), 0);
            chk_i("abort_s_tready", int'(sready(s)), 0);
            chk_i("abort_m_tvalid", int'(mvalid(s)), 0);
            chk_i("abort_m_tlast", int'(mlast(s)), 0);
            chk_w("abort_m_tdata", mdata(s), '0);
            chk_i("abort_done", int'(done[s]), 0);
            eq[s].delete();
            first_pend[s] = 1'b0;
            prev_stall[s] = 1'b0;
            @(posedge clk);
            #1 reset = 1'b0;
            return;
         end
      end
      set_px(s, 1'b0, '0);
      t = 0;
      while (busy[s]) begin
         @(negedge clk);
         if (++t > 5000) die("frame_end");
      end
      @(posedge clk);
      #1;
      chk_i("windows_per_frame", wcnt[s] - wc0, win_count(n, m, k));
      chk_i("done_pulses", ndone[s] - nd0, 1);
      chk_i("scoreboard_empty", eq[s].size(), 0);
   endtask

   task automatic bad_cfg(int n, int m);
      cols[0]  = CW'(n);
      rows[0]  = RW'(m);
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      chk_i("cfg_err_pulse", int'(cerr[0]), 1);
      chk_i("cfg_err_busy", int'(busy[0]), 0);
      chk_i("cfg_err_s_tready", int'(sready(0)), 0);
      @(posedge clk);
      #1;
      chk_i("cfg_err_one_cycle", int'(cerr[0]), 0);
      chk_i("cfg_err_still_idle", int'(busy[0]), 0);
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         start[s] = 1'b0;
         cols[s]  = '0;
         rows[s]  = '0;
         set_px(s, 1'b0, '0);
      end
      repeat (3) @(posedge clk);
      #1;
      chk_i("reset_busy", int'(busy[0]), 0);
      chk_i("reset_m_tvalid", int'(mvalid(0)), 0);
      chk_i("reset_s_tready", int'(sready(0)), 0);
      chk_w("reset_m_tdata", mdata(0), '0);
      chk_i("reset_flags", int'(done[0] | cerr[0] | mlast(0)), 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      run_frame(0, 5, 5, 1'b1, -1, -1);
      rnd_rdy = 1'b1;
      run_frame(0, 5, 5, 1'b1, 6, -1);
      run_frame(0, 6, 7, 1'b0, -1, -1);
      rnd_rdy = 1'b0;
      bad_cfg(2, 5);
      bad_cfg(5, 2);
      bad_cfg(641, 5);
      run_frame(0, 5, 5, 1'b1, -1, 8);
      run_frame(0, 5, 5, 1'b1, -1, -1);
      chk638 = 1'b1;
      wcnt[0] = 0;
      run_frame(0, 640, 4, 1'b0, -1, -1);
      chk638 = 1'b0;
      run_frame(1, 7, 6, 1'b0, -1, -1);
      run_frame(1, 7, 6, 1'b0, -1, -1);
      rnd_rdy = 1'b1;
      run_frame(1, 8, 7, 1'b0, -1, -1);
      rnd_rdy = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
